// File: rtl/mc_fir_engine_if.sv
// ============================================================================
// Module      : mc_fir_engine_if
// Description : Stream, tap-write and control bundle for mc_fir_engine.
//               slave modport  = engine side, master modport = client side.
//               Input side : i_valid/o_ready, i_chan, i_sample
//               Tap writes : i_tap_wr, i_tap_chan, i_tap_addr, i_tap_data
//               Control    : i_out_len, i_flush, o_busy, o_flush_done
//               Output side: o_valid/i_ready, o_chan, o_result, o_last, o_sat
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_fir_engine_if #(
    parameter int NCH   = 2,
    parameter int NTAPS = 8,
    parameter int IW    = 12,
    parameter int TW    = 12,
    parameter int OW    = IW + TW + $clog2(NTAPS),
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
);
    logic                 i_valid;
    logic                 o_ready;
    logic [CW-1:0]        i_chan;
    logic signed [IW-1:0] i_sample;

    logic                 i_tap_wr;
    logic [CW-1:0]        i_tap_chan;
    logic [AW-1:0]        i_tap_addr;
    logic signed [TW-1:0] i_tap_data;

    logic [15:0]          i_out_len;
    logic                 i_flush;

    logic                 o_valid;
    logic                 i_ready;
    logic [CW-1:0]        o_chan;
    logic signed [OW-1:0] o_result;
    logic                 o_last;
    logic                 o_sat;
    logic                 o_busy;
    logic                 o_flush_done;

    modport slave (
        input  i_valid, i_chan, i_sample,
        input  i_tap_wr, i_tap_chan, i_tap_addr, i_tap_data,
        input  i_out_len, i_flush, i_ready,
        output o_ready, o_valid, o_chan, o_result, o_last, o_sat,
        output o_busy, o_flush_done
    );

    modport master (
        output i_valid, i_chan, i_sample,
        output i_tap_wr, i_tap_chan, i_tap_addr, i_tap_data,
        output i_out_len, i_flush, i_ready,
        input  o_ready, o_valid, o_chan, o_result, o_last, o_sat,
        input  o_busy, o_flush_done
    );
endinterface

`default_nettype wire

// File: rtl/mc_fir_engine.sv
// ============================================================================
// Module      : mc_fir_engine
// Description : Multi-channel time-multiplexed FIR engine. NCH channels share
//               one parallel multiplier array; each channel owns a delay line
//               and a runtime-writable tap bank. Two-stage pipeline
//               (products, then adder tree) with valid/ready on both sides,
//               per-channel frame counters driving o_last, and a zero-
//               injection flush sequence (RUN -> FLUSH -> DRAIN -> RUN).
// Ports       : i_clk      - clock, rising edge
//               i_reset_n  - asynchronous active-low reset
//               bus        - mc_fir_engine_if.slave (stream, taps, control)
// Options     : FIR_SAT_EN - when defined, results are clipped to IW+TW
//               signed bits and o_sat flags the clip; otherwise the result
//               is full precision and o_sat is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_fir_engine #(
    parameter int NCH   = 2,
    parameter int NTAPS = 8,
    parameter int IW    = 12,
    parameter int TW    = 12,
    parameter int OW    = IW + TW + $clog2(NTAPS),
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  wire logic      i_clk,
    input  wire logic      i_reset_n,
    mc_fir_engine_if.slave bus
);

    localparam int PW = IW + TW;                               // product width
    localparam int RW = (NTAPS > 2) ? $clog2(NTAPS - 1) : 1;   // flush round width

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_FLUSH = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    localparam logic [RW-1:0] c_LAST_ROUND = RW'(NTAPS - 2);
    localparam logic [CW-1:0] c_LAST_CH    = CW'(NCH - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 w_flush_done_nxt;
    logic                 r_flush_done;

    logic                 w_adv;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_inject;
    logic                 w_ld;
    logic                 w_ld_force;
    logic [CW-1:0]        w_ld_chan;
    logic signed [IW-1:0] w_ld_sample;
    logic                 w_chan_ok;
    logic                 w_tap_chan_ok;
    logic                 w_tap_addr_ok;

    logic [CW-1:0]        r_inj_ch;
    logic [RW-1:0]        r_round;

    logic signed [IW-1:0] r_hist [NCH][NTAPS-1];
    logic signed [TW-1:0] r_tap  [NCH][NTAPS];
    logic signed [PW-1:0] w_prod [NTAPS];
    logic signed [PW-1:0] r_prod [NTAPS];

    logic                 r_s1_valid;
    logic                 r_s1_force;
    logic [CW-1:0]        r_s1_chan;

    logic signed [OW-1:0] w_sum;
    logic signed [OW-1:0] w_res;
    logic                 w_sat;

    logic                 r_valid;
    logic [CW-1:0]        r_chan;
    logic signed [OW-1:0] r_result;
    logic                 r_sat;
    logic                 r_force;
    logic                 w_last;
    logic [15:0]          r_cnt [NCH];

    // ------------------------------------------------------------------------
    // Range checks: when NCH / NTAPS fill their index width every code is
    // legal, so the comparison is dropped rather than left constant.
    // ------------------------------------------------------------------------
    generate
        if (NCH == (1 << CW)) begin : g_chan_full
            assign w_chan_ok     = 1'b1;
            assign w_tap_chan_ok = 1'b1;
        end else begin : g_chan_chk
            assign w_chan_ok     = (bus.i_chan < CW'(NCH));
            assign w_tap_chan_ok = (bus.i_tap_chan < CW'(NCH));
        end
        if (NTAPS == (1 << AW)) begin : g_addr_full
            assign w_tap_addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign w_tap_addr_ok = (bus.i_tap_addr < AW'(NTAPS));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Handshake and stage-1 load source (external sample or flush zero)
    // ------------------------------------------------------------------------
    assign w_adv       = !r_valid || bus.i_ready;
    assign w_ready     = w_adv && (r_state == c_ST_RUN);
    assign w_accept    = bus.i_valid && w_ready;
    assign w_inject    = w_adv && (r_state == c_ST_FLUSH);
    assign w_ld_chan   = w_inject ? r_inj_ch : bus.i_chan;
    assign w_ld_sample = w_inject ? '0 : bus.i_sample;
    // Out-of-range channels still take the handshake but load nothing.
    assign w_ld        = w_inject || (w_accept && w_chan_ok);
    // The last flush round carries each channel's final flushed output.
    assign w_ld_force  = w_inject && (r_round == c_LAST_ROUND);

    // ------------------------------------------------------------------------
    // Flush FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= c_ST_RUN;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_done <= w_flush_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_done_nxt = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (bus.i_flush) w_state_nxt = c_ST_FLUSH;
            end
            c_ST_FLUSH: begin
                if (w_inject && (r_round == c_LAST_ROUND) && (r_inj_ch == c_LAST_CH))
                    w_state_nxt = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                // Stage 1 empty and the output register already handshaken.
                if (!r_s1_valid && !r_valid) begin
                    w_state_nxt      = c_ST_RUN;
                    w_flush_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_RUN;
        endcase
    end

    // Injection position: channel rotates fastest, round counts passes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_inj_ch <= '0;
            r_round  <= '0;
        end else if ((r_state == c_ST_RUN) && bus.i_flush) begin
            r_inj_ch <= '0;
            r_round  <= '0;
        end else if (w_inject) begin
            if (r_inj_ch == c_LAST_CH) begin
                r_inj_ch <= '0;
                r_round  <= r_round + 1'b1;
            end else begin
                r_inj_ch <= r_inj_ch + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tap banks: writable every cycle, independent of the stall state
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < NTAPS; k++) begin
                    r_tap[c][k] <= (k == 0) ? TW'(1) : '0;
                end
            end
        end else if (bus.i_tap_wr && w_tap_chan_ok && w_tap_addr_ok) begin
            r_tap[bus.i_tap_chan][bus.i_tap_addr] <= bus.i_tap_data;
        end
    end

    // ------------------------------------------------------------------------
    // Delay lines hold the NTAPS-1 previous samples; the incoming sample is
    // tap 0 and feeds the multipliers directly.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < NTAPS - 1; k++) begin
                    r_hist[c][k] <= '0;
                end
            end
        end else if (w_ld) begin
            r_hist[w_ld_chan][0] <= w_ld_sample;
            for (int k = 1; k < NTAPS - 1; k++) begin
                r_hist[w_ld_chan][k] <= r_hist[w_ld_chan][k-1];
            end
        end
    end

    always_comb begin
        w_prod[0] = PW'(w_ld_sample) * PW'(r_tap[w_ld_chan][0]);
        for (int k = 1; k < NTAPS; k++) begin
            w_prod[k] = PW'(r_hist[w_ld_chan][k-1]) * PW'(r_tap[w_ld_chan][k]);
        end
    end

    // Stage 1: registered products
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_force <= 1'b0;
            r_s1_chan  <= '0;
            for (int k = 0; k < NTAPS; k++) r_prod[k] <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_ld;
            if (w_ld) begin
                r_s1_force <= w_ld_force;
                r_s1_chan  <= w_ld_chan;
                for (int k = 0; k < NTAPS; k++) r_prod[k] <= w_prod[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Adder tree: products sign-extended to OW, which cannot overflow.
    // ------------------------------------------------------------------------
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_sum = w_sum + OW'(r_prod[k]);
        end
    end

`ifdef FIR_SAT_EN
    // In range iff bits [OW-1:PW-1] are all copies of the sign bit.
    always_comb begin
        w_res = w_sum;
        w_sat = 1'b0;
        if (w_sum[OW-1:PW-1] != {(OW-PW+1){w_sum[OW-1]}}) begin
            w_sat = 1'b1;
            w_res = w_sum[OW-1] ? {{(OW-PW+1){1'b1}}, {(PW-1){1'b0}}}
                                : {{(OW-PW+1){1'b0}}, {(PW-1){1'b1}}};
        end
    end
`else
    assign w_res = w_sum;
    assign w_sat = 1'b0;
`endif

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid  <= 1'b0;
            r_chan   <= '0;
            r_result <= '0;
            r_sat    <= 1'b0;
            r_force  <= 1'b0;
        end else if (w_adv) begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_chan   <= r_s1_chan;
                r_result <= w_res;
                r_sat    <= w_sat;
                r_force  <= r_s1_force;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame counters: o_last is derived from the held output's channel count,
    // so it stays stable while stalled.
    // ------------------------------------------------------------------------
    assign w_last = r_valid &&
                    (r_force ||
                     ((bus.i_out_len != 16'd0) && ((r_cnt[r_chan] + 16'd1) == bus.i_out_len)));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < NCH; c++) r_cnt[c] <= 16'd0;
        end else if (r_valid && bus.i_ready) begin
            r_cnt[r_chan] <= w_last ? 16'd0 : (r_cnt[r_chan] + 16'd1);
        end
    end

    assign bus.o_ready      = w_ready;
    assign bus.o_valid      = r_valid;
    assign bus.o_chan       = r_chan;
    assign bus.o_result     = r_result;
    assign bus.o_last       = w_last;
    assign bus.o_sat        = r_sat;
    assign bus.o_busy       = (r_state != c_ST_RUN);
    assign bus.o_flush_done = r_flush_done;

endmodule

`default_nettype wire

// File: tb/tb_mc_fir_engine.sv
// ============================================================================
// Module      : tb_mc_fir_engine
// Description : Scoreboard bench for mc_fir_engine. A reference model
//               computes each expected result when a sample is accepted; the
//               monitor pops and compares on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_fir_engine;

    localparam int NCH   = 2;
    localparam int NTAPS = 8;
    localparam int IW    = 12;
    localparam int TW    = 12;
    localparam int PW    = IW + TW;

    typedef struct {
        longint chan;
        longint res;
        longint last;
        longint sat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_fir_engine_if #(.NCH(NCH), .NTAPS(NTAPS), .IW(IW), .TW(TW)) bus ();

    mc_fir_engine #(.NCH(NCH), .NTAPS(NTAPS), .IW(IW), .TW(TW)) u_dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int     total = 0;
    int     bad   = 0;
    exp_t   sb[$];
    int     done_cnt  = 0;
    int     last_cnt0 = 0;
    longint last_res  = 0;
    longint last_sat  = 0;

    int m_tap  [NCH][NTAPS];
    int m_hist [NCH][NTAPS-1];
    int m_cnt  [NCH];
    int m_len = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < NTAPS; k++) m_tap[c][k] = (k == 0) ? 1 : 0;
            for (int k = 0; k < NTAPS - 1; k++) m_hist[c][k] = 0;
            m_cnt[c] = 0;
        end
    endfunction

    function automatic void model_push(input int ch, input int s, input bit force_last);
        exp_t   e;
        longint acc;
        acc = longint'(s) * m_tap[ch][0];
        for (int k = 1; k < NTAPS; k++) acc += longint'(m_hist[ch][k-1]) * m_tap[ch][k];
        for (int k = NTAPS - 2; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
        m_hist[ch][0] = s;
        e.sat = 0;
`ifdef FIR_SAT_EN
        if (acc > (longint'(1) << (PW - 1)) - 1) begin
            acc = (longint'(1) << (PW - 1)) - 1;
            e.sat = 1;
        end else if (acc < -(longint'(1) << (PW - 1))) begin
            acc = -(longint'(1) << (PW - 1));
            e.sat = 1;
        end
`endif
        e.chan = ch;
        e.res  = acc;
        e.last = (force_last || (m_len != 0 && m_cnt[ch] + 1 == m_len)) ? 1 : 0;
        m_cnt[ch] = (e.last != 0) ? 0 : m_cnt[ch] + 1;
        sb.push_back(e);
    endfunction

    // Output monitor: one comparison set per handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_flush_done) done_cnt++;
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("o_chan",   longint'(bus.o_chan), e.chan);
                    check("o_result", longint'(bus.o_result), e.res);
                    check("o_last",   longint'(bus.o_last), e.last);
                    check("o_sat",    longint'(bus.o_sat), e.sat);
                    if (bus.o_last && bus.o_chan == 0) last_cnt0++;
                    last_res = longint'(bus.o_result);
                    last_sat = longint'(bus.o_sat);
                end
            end
        end
    end

    task automatic send(input int ch, input int s);
        bit acc = 1'b0;
        bus.i_valid  = 1'b1;
        bus.i_chan   = ch[0:0];
        bus.i_sample = IW'(s);
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = bus.o_ready;
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        check("send_accept", longint'(acc), 1);
        if (acc) model_push(ch, s, 1'b0);
    endtask

    task automatic tap_write(input int ch, input int addr, input int d);
        bus.i_tap_wr   = 1'b1;
        bus.i_tap_chan = ch[0:0];
        bus.i_tap_addr = addr[2:0];
        bus.i_tap_data = TW'(d);
        @(posedge clk);
        #1;
        bus.i_tap_wr = 1'b0;
        m_tap[ch][addr] = d;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = (sb.size() == 0) && !bus.o_valid && !bus.o_busy;
        end
        check("drain", longint'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        for (int r = 0; r < NTAPS - 1; r++) begin
            for (int c = 0; c < NCH; c++) model_push(c, 0, r == NTAPS - 2);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  longint'(bus.o_valid), 0);
        check({tag, "_result"}, longint'(bus.o_result), 0);
        check({tag, "_chan"},   longint'(bus.o_chan), 0);
        check({tag, "_last"},   longint'(bus.o_last), 0);
        check({tag, "_sat"},    longint'(bus.o_sat), 0);
        check({tag, "_busy"},   longint'(bus.o_busy), 0);
        check({tag, "_done"},   longint'(bus.o_flush_done), 0);
        check({tag, "_ready"},  longint'(bus.o_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        bus.i_valid = 0; bus.i_chan = 0; bus.i_sample = 0;
        bus.i_tap_wr = 0; bus.i_tap_chan = 0; bus.i_tap_addr = 0; bus.i_tap_data = 0;
        bus.i_out_len = 0; bus.i_flush = 0; bus.i_ready = 1;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Programmed taps: ch0 impulse response interleaved with ch1 passthrough
        for (int k = 0; k < NTAPS; k++) tap_write(0, k, 8 + k);
        send(0, 1);
        send(1, 3);
        for (int k = 0; k < 7; k++) send(0, 0);
        wait_drain();

        // Flush: ch0 1, 2 then zero injection on both channels
        send(0, 1);
        send(0, 2);
        d0 = done_cnt;
        do_flush();
        @(negedge clk);
        check("flush_ready", longint'(bus.o_ready), 0);
        check("flush_busy",  longint'(bus.o_busy), 1);
        wait_drain();
        @(negedge clk);
        check("flush_done_once", longint'(done_cnt - d0), 1);
        @(posedge clk);
        #1;
        send(0, 1);
        wait_drain();
        check("post_flush_impulse", last_res, 8);

        // Stall: consumer holds i_ready low for 3 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 6; i++) send(i % 2, 10 + i);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.i_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid", longint'(bus.o_valid), 1);
                    check("stall_ready", longint'(bus.o_ready), 0);
                    if (sb.size() > 0) check("stall_hold", longint'(bus.o_result), sb[0].res);
                end
                @(posedge clk);
                #1;
                bus.i_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset in the middle of a flush
        do_flush();
        repeat (2) @(posedge clk);
        #1;
        check("midflush_busy", longint'(bus.o_busy), 1);
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        @(negedge clk);
        check_reset_outputs("rst1");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", longint'(bus.o_busy), 0);
        @(posedge clk);
        #1;

        // Frame length 2 on ch0: o_last on outputs 2, 4, 6
        bus.i_out_len = 16'd2;
        m_len = 2;
        last_cnt0 = 0;
        for (int i = 1; i <= 6; i++) send(0, i);
        wait_drain();
        check("frame_last_count", longint'(last_cnt0), 3);
        bus.i_out_len = 16'd0;
        m_len = 0;

        // Passthrough after reset, with two-cycle latency
        send(0, 1);
        @(negedge clk);
        check("lat_s1", longint'(bus.o_valid), 0);
        @(negedge clk);
        check("lat_s2", longint'(bus.o_valid), 1);
        check("lat_res", longint'(bus.o_result), 1);
        @(posedge clk);
        #1;
        send(0, 0);
        send(0, 0);
        send(1, 5);
        wait_drain();
        check("passthru_ch1", last_res, 5);

        // Extreme values: all taps and samples at the negative limit
        for (int k = 0; k < NTAPS; k++) tap_write(0, k, -2048);
        for (int i = 0; i < NTAPS; i++) send(0, -2048);
        wait_drain();
`ifdef FIR_SAT_EN
        check("extreme_res", last_res, 8388607);
        check("extreme_sat", last_sat, 1);
`else
        check("extreme_res", last_res, 33554432);
        check("extreme_sat", last_sat, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
